mem_port_arbiter: RTL and testbench

- Shares one 1-read/1-write word memory (async read, sync write, byte address with word index in addr[ADDR_W-1:2]) between two requesters, e.g. LSU (port 0) and program loader/debug (port 1).
- Provides valid/ready request handshakes and round-robin arbitration.
- Converts byte-enable partial stores into a two-cycle read-merge-write sequence; the memory itself writes only whole words.

---
 rtl/mem_port_arbiter.sv | 162 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-port valid/ready arbiter in front of a 1R/1W word memory; partial stores
// become a read-merge-write. Define MEM_ARB_FIXED_PRI_EN for fixed port-0 priority.
module mem_port_arbiter #(
  parameter  int WIDTH  = 32,
  parameter  int DEPTH  = 4,
  localparam int BE_W   = WIDTH / 8,
  localparam int ADDR_W = $clog2(DEPTH) + 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_we,
  input  logic [BE_W-1:0]   req0_be,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [WIDTH-1:0]  req0_wdata,
  output logic              resp0_valid,
  output logic [WIDTH-1:0]  resp0_rdata,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_we,
  input  logic [BE_W-1:0]   req1_be,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [WIDTH-1:0]  req1_wdata,
  output logic              resp1_valid,
  output logic [WIDTH-1:0]  resp1_rdata,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [WIDTH-1:0]  mem_rd_dout,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [WIDTH-1:0]  mem_wr_din,
  output logic              mem_we
);

  typedef enum logic {IDLE, MERGE_WR} state_t;

  state_t              state, state_nx;
  logic [ADDR_W-1:0]   rd_addr_q;
  logic [ADDR_W-1:0]   merge_addr_q;
  logic [WIDTH-1:0]    merge_data_q;
  logic                merge_idx_q;

  logic                win;
  logic                grant;
  logic                sel_we;
  logic [BE_W-1:0]     sel_be;
  logic [ADDR_W-1:0]   sel_addr;
  logic [WIDTH-1:0]    sel_wdata;
  logic [ADDR_W-1:0]   sel_word_addr;
  logic [WIDTH-1:0]    merged;
  logic                is_read, is_full, is_zero, is_partial;

`ifdef MEM_ARB_FIXED_PRI_EN
  assign win = req0_valid ? 1'b0 : 1'b1;
`else
  logic rr_ptr;
  assign win = (req0_valid && req1_valid) ? rr_ptr : (req1_valid ? 1'b1 : 1'b0);
`endif

  // Handshake: a request transfers in the cycle where valid && ready; ready is
  // raised combinationally for the winner only in IDLE, and the requester must
  // hold its payload stable until then.
  assign grant = (state == IDLE) && rst && (req0_valid || req1_valid);

  assign sel_we        = win ? req1_we    : req0_we;
  assign sel_be        = win ? req1_be    : req0_be;
  assign sel_addr      = win ? req1_addr  : req0_addr;
  assign sel_wdata     = win ? req1_wdata : req0_wdata;
  assign sel_word_addr = {sel_addr[ADDR_W-1:2], 2'b00};

  assign is_read    = !sel_we;
  assign is_full    = sel_we && (sel_be == {BE_W{1'b1}});
  assign is_zero    = sel_we && (sel_be == {BE_W{1'b0}});
  assign is_partial = sel_we && !is_full && !is_zero;

  always_comb begin
    merged = '0;
    for (int k = 0; k < BE_W; k++) begin
      merged[k*8 +: 8] = sel_be[k] ? sel_wdata[k*8 +: 8] : mem_rd_dout[k*8 +: 8];
    end
  end

  always_comb begin
    state_nx    = state;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    mem_we      = 1'b0;
    mem_wr_addr = '0;
    mem_wr_din  = '0;
    mem_rd_addr = rd_addr_q;
    case (state)
      IDLE: begin
        if (grant) begin
          req0_ready = !win;
          req1_ready = win;
          if (is_read || is_partial) mem_rd_addr = sel_addr;
          if (is_full) begin
            mem_we      = 1'b1;
            mem_wr_addr = sel_word_addr;
            mem_wr_din  = sel_wdata;
          end
          if (is_partial) state_nx = MERGE_WR;
        end
      end
      MERGE_WR: begin
        mem_we      = 1'b1;
        mem_wr_addr = merge_addr_q;
        mem_wr_din  = merge_data_q;
        state_nx    = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      rd_addr_q    <= '0;
      merge_addr_q <= '0;
      merge_data_q <= '0;
      merge_idx_q  <= 1'b0;
      resp0_valid  <= 1'b0;
      resp1_valid  <= 1'b0;
      resp0_rdata  <= '0;
      resp1_rdata  <= '0;
`ifndef MEM_ARB_FIXED_PRI_EN
      rr_ptr       <= 1'b0;
`endif
    end else begin
      state       <= state_nx;
      rd_addr_q   <= mem_rd_addr;
      resp0_valid <= 1'b0;
      resp1_valid <= 1'b0;
      if (grant) begin
`ifndef MEM_ARB_FIXED_PRI_EN
        rr_ptr <= ~win;
`endif
        if (is_read) begin
          if (win) begin
            resp1_valid <= 1'b1;
            resp1_rdata <= mem_rd_dout;
          end else begin
            resp0_valid <= 1'b1;
            resp0_rdata <= mem_rd_dout;
          end
        end else if (is_partial) begin
          merge_addr_q <= sel_word_addr;
          merge_data_q <= merged;
          merge_idx_q  <= win;
        end else begin
          if (win) resp1_valid <= 1'b1;
          else     resp0_valid <= 1'b1;
        end
      end
      // The merged word lands at the end of MERGE_WR; acknowledge right after.
      if (state == MERGE_WR) begin
        if (merge_idx_q) resp1_valid <= 1'b1;
        else             resp0_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural 4-word memory;
// expectations for both the round-robin and MEM_ARB_FIXED_PRI_EN builds.
module tb_mem_port_arbiter;

  localparam int WIDTH  = 32;
  localparam int DEPTH  = 4;
  localparam int BE_W   = WIDTH / 8;
  localparam int ADDR_W = $clog2(DEPTH) + 2;

  logic              clk;
  logic              rst;
  logic              req0_valid, req0_ready, req0_we;
  logic [BE_W-1:0]   req0_be;
  logic [ADDR_W-1:0] req0_addr;
  logic [WIDTH-1:0]  req0_wdata;
  logic              resp0_valid;
  logic [WIDTH-1:0]  resp0_rdata;
  logic              req1_valid, req1_ready, req1_we;
  logic [BE_W-1:0]   req1_be;
  logic [ADDR_W-1:0] req1_addr;
  logic [WIDTH-1:0]  req1_wdata;
  logic              resp1_valid;
  logic [WIDTH-1:0]  resp1_rdata;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic [WIDTH-1:0]  mem_rd_dout;
  logic [ADDR_W-1:0] mem_wr_addr;
  logic [WIDTH-1:0]  mem_wr_din;
  logic              mem_we;

  int n_vec = 0;
  int n_err = 0;

  logic [WIDTH-1:0] mem [DEPTH] = '{32'hA0A0A0A0, 32'hB1B1B1B1, 32'hC2C2C2C2, 32'hD3D3D3D3};

  mem_port_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
    .req0_be(req0_be), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .resp0_valid(resp0_valid), .resp0_rdata(resp0_rdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
    .req1_be(req1_be), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .resp1_valid(resp1_valid), .resp1_rdata(resp1_rdata),
    .mem_rd_addr(mem_rd_addr), .mem_rd_dout(mem_rd_dout),
    .mem_wr_addr(mem_wr_addr), .mem_wr_din(mem_wr_din), .mem_we(mem_we)
  );

  // Clock / reset and memory model
  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rd_dout = mem[mem_rd_addr[ADDR_W-1:2]];

  always @(posedge clk) begin
    if (mem_we) mem[mem_wr_addr[ADDR_W-1:2]] <= mem_wr_din;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog expired");
  end

  // Driver tasks
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic drive0(input logic v, input logic we, input logic [BE_W-1:0] be,
                        input logic [ADDR_W-1:0] addr, input logic [WIDTH-1:0] wdata);
    req0_valid = v; req0_we = we; req0_be = be; req0_addr = addr; req0_wdata = wdata;
  endtask

  task automatic drive1(input logic v, input logic we, input logic [BE_W-1:0] be,
                        input logic [ADDR_W-1:0] addr, input logic [WIDTH-1:0] wdata);
    req1_valid = v; req1_we = we; req1_be = be; req1_addr = addr; req1_wdata = wdata;
  endtask

  // Scoreboard check
  task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  logic [3:0] t_r0, t_r1, t_v0, t_v1;
  logic       t5_v0, t5_v1;

  initial begin
`ifdef MEM_ARB_FIXED_PRI_EN
    t_r0 = 4'b1111; t_r1 = 4'b0000; t_v0 = 4'b1110; t_v1 = 4'b0000;
    t5_v0 = 1'b1; t5_v1 = 1'b0;
`else
    t_r0 = 4'b0101; t_r1 = 4'b1010; t_v0 = 4'b1010; t_v1 = 4'b0100;
    t5_v0 = 1'b0; t5_v1 = 1'b1;
`endif
    rst = 1'b0;
    drive0(1'b1, 1'b0, 4'h0, 4'h4, '0);
    drive1(1'b0, 1'b0, 4'h0, 4'h0, '0);

    // Reset values, with a request pending that must not be granted
    sample(); sample();
    check("rst_ready0", req0_ready, 0);
    check("rst_resp0_valid", resp0_valid, 0);
    check("rst_resp0_rdata", resp0_rdata, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_rd_addr", mem_rd_addr, 0);
    check("rst_mem_wr_addr", mem_wr_addr, 0);
    check("rst_mem_wr_din", mem_wr_din, 0);
    drive0(1'b0, 1'b0, 4'h0, 4'h0, '0);
    next_cycle();
    rst = 1'b1;
    sample();

    // Both ports read continuously: arbitration order per build
    for (int c = 0; c < 4; c++) begin
      next_cycle();
      drive0(1'b1, 1'b0, 4'h0, 4'h0, '0);
      drive1(1'b1, 1'b0, 4'h0, 4'h4, '0);
      sample();
      check($sformatf("arb_ready0_c%0d", c), req0_ready, t_r0[c]);
      check($sformatf("arb_ready1_c%0d", c), req1_ready, t_r1[c]);
      check($sformatf("arb_resp0_c%0d", c), resp0_valid, t_v0[c]);
      check($sformatf("arb_resp1_c%0d", c), resp1_valid, t_v1[c]);
    end
    next_cycle();
    drive0(1'b0, 1'b0, 4'h0, 4'h0, '0);
    sample();
    check("arb_p1_alone_ready1", req1_ready, 1);
    check("arb_c4_resp0", resp0_valid, t5_v0);
    check("arb_c4_resp1", resp1_valid, t5_v1);
    next_cycle();
    drive1(1'b0, 1'b0, 4'h0, 4'h0, '0);
    sample();
    check("arb_last_resp1", resp1_valid, 1);
    check("arb_last_rdata1", resp1_rdata, 32'hB1B1B1B1);
    check("arb_idle_ready1", req1_ready, 0);

    // Full write then read back
    next_cycle();
    drive0(1'b1, 1'b1, 4'hF, 4'h8, 32'hDEADBEEF);
    sample();
    check("fw_ready0", req0_ready, 1);
    check("fw_mem_we", mem_we, 1);
    check("fw_wr_addr", mem_wr_addr, 4'h8);
    check("fw_wr_din", mem_wr_din, 32'hDEADBEEF);
    next_cycle();
    drive0(1'b1, 1'b0, 4'h0, 4'h8, '0);
    sample();
    check("fw_resp0", resp0_valid, 1);
    check("rd_ready0", req0_ready, 1);
    check("rd_rd_addr", mem_rd_addr, 4'h8);
    check("rd_mem_we", mem_we, 0);
    next_cycle();
    drive0(1'b0, 1'b0, 4'h0, 4'h0, '0);
    sample();
    check("rd_resp0", resp0_valid, 1);
    check("rd_rdata0", resp0_rdata, 32'hDEADBEEF);
    check("rd_mem_word2", mem[2], 32'hDEADBEEF);
    check("idle_rd_addr_hold", mem_rd_addr, 4'h8);
    next_cycle();
    sample();
    check("rd_resp0_one_cycle", resp0_valid, 0);

    // Zero-BE write: ack only; full write with unaligned address
    next_cycle();
    drive1(1'b1, 1'b1, 4'h0, 4'h0, 32'hFFFFFFFF);
    sample();
    check("zbe_ready1", req1_ready, 1);
    check("zbe_mem_we", mem_we, 0);
    next_cycle();
    drive1(1'b0, 1'b0, 4'h0, 4'h0, '0);
    drive0(1'b1, 1'b1, 4'hF, 4'hD, 32'h0BADF00D);
    sample();
    check("zbe_resp1", resp1_valid, 1);
    check("zbe_rdata1_hold", resp1_rdata, 32'hB1B1B1B1);
    check("ua_wr_addr", mem_wr_addr, 4'hC);
    check("ua_wr_din", mem_wr_din, 32'h0BADF00D);
    next_cycle();
    drive0(1'b0, 1'b0, 4'h0, 4'h0, '0);
    sample();
    check("ua_resp0", resp0_valid, 1);
    check("ua_rdata0_hold", resp0_rdata, 32'hDEADBEEF);
    check("ua_mem_word3", mem[3], 32'h0BADF00D);
    check("zbe_mem_word0", mem[0], 32'hA0A0A0A0);

    // Partial write (read-merge-write) followed immediately by a read
    next_cycle();
    drive0(1'b1, 1'b1, 4'hF, 4'h4, 32'h11223344);
    sample();
    check("pre_mem_we", mem_we, 1);
    next_cycle();
    drive0(1'b0, 1'b0, 4'h0, 4'h0, '0);
    drive1(1'b1, 1'b1, 4'b0010, 4'h4, 32'h0000AA00);
    sample();
    check("pw_ready1", req1_ready, 1);
    check("pw_acc_mem_we", mem_we, 0);
    check("pw_acc_rd_addr", mem_rd_addr, 4'h4);
    next_cycle();
    drive1(1'b0, 1'b0, 4'h0, 4'h0, '0);
    drive0(1'b1, 1'b0, 4'h0, 4'h4, '0);
    sample();
    check("mw_ready0", req0_ready, 0);
    check("mw_ready1", req1_ready, 0);
    check("mw_mem_we", mem_we, 1);
    check("mw_wr_addr", mem_wr_addr, 4'h4);
    check("mw_wr_din", mem_wr_din, 32'h1122AA44);
    check("mw_resp1_early", resp1_valid, 0);
    next_cycle();
    sample();
    check("raw_ready0", req0_ready, 1);
    check("raw_resp1", resp1_valid, 1);
    check("raw_mem_we", mem_we, 0);
    next_cycle();
    drive0(1'b0, 1'b0, 4'h0, 4'h0, '0);
    sample();
    check("raw_resp0", resp0_valid, 1);
    check("raw_rdata0", resp0_rdata, 32'h1122AA44);
    check("raw_resp1_one_cycle", resp1_valid, 0);

    // Reset while in MERGE_WR
    next_cycle();
    drive0(1'b1, 1'b1, 4'b0001, 4'h0, 32'h00000055);
    sample();
    check("rm_ready0", req0_ready, 1);
    next_cycle();
    rst = 1'b0;
    drive0(1'b0, 1'b0, 4'h0, 4'h0, '0);
    sample();
    check("rm_mem_we", mem_we, 0);
    check("rm_resp0", resp0_valid, 0);
    check("rm_rdata0", resp0_rdata, 0);
    check("rm_wr_din", mem_wr_din, 0);
    check("rm_rd_addr", mem_rd_addr, 0);
    next_cycle();
    rst = 1'b1;
    sample();
    check("rm_after_mem_we", mem_we, 0);
    check("rm_after_resp0", resp0_valid, 0);
    check("rm_mem_word0", mem[0], 32'hA0A0A0A0);
    next_cycle();
    drive1(1'b1, 1'b0, 4'h0, 4'h0, '0);
    sample();
    check("rm_next_ready1", req1_ready, 1);
    next_cycle();
    drive1(1'b0, 1'b0, 4'h0, 4'h0, '0);
    sample();
    check("rm_next_resp1", resp1_valid, 1);
    check("rm_next_rdata1", resp1_rdata, 32'hA0A0A0A0);

    // Final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
